// File: rtl/cam_pkg.sv
// cam_pkg: shared types and defaults for the camera capture front end.
//   cam_state_t  - capture FSM states
//   rgb565_t     - 16-bit RGB565 pixel
//   CAM_WIDTH / CAM_HEIGHT / CAM_SYNC_STAGES - default geometry and sync depth
//   test_pattern - builds the synthetic pixel used when CAM_TEST_PATTERN_EN is defined
package cam_pkg;

  localparam int CAM_WIDTH       = 640;
  localparam int CAM_HEIGHT      = 480;
  localparam int CAM_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    S_WAIT_VSYNC,
    S_BLANK,
    S_HI,
    S_LO
  } cam_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Pattern pixel: {line[4:0], pix[5:0], pix[4:0]}
  function automatic rgb565_t test_pattern(input logic [4:0] line, input logic [5:0] pix);
    rgb565_t p;
    p.r = line;
    p.g = pix;
    p.b = pix[4:0];
    return p;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-bit flip-flop chain synchronizer.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears every stage
//   d     - asynchronous input bus
//   q     - synchronized output, STAGES cycles behind d
// Every bit uses the same depth so a bus and its strobe stay aligned.
module sync_ff
  import cam_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = CAM_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift register; stage 0 is the only one that sees the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/camera_capture.sv
// camera_capture: OV7670-style parallel camera front end.
// Synchronizes pclk/href/vsync/data into the system clock domain, pairs bytes
// into RGB565 pixels and flags malformed lines and frames.
// Ports:
//   system_clk_in   - system clock (>= 4x cam_pclk_in)
//   rst_n_in        - asynchronous active-low reset
//   cam_pclk_in     - camera pixel clock (asynchronous)
//   cam_href_in     - line active (asynchronous)
//   cam_vsync_in    - frame sync, high between frames (asynchronous)
//   cam_data_in     - camera byte, changes on pclk falling edge
//   pixel_out       - last assembled pixel {first byte, second byte}
//   valid_pixel_out - one-cycle pulse per completed pixel
//   frame_done_out  - one-cycle pulse per counted vsync rising edge
//   line_err_out    - sticky: bad line length or dangling byte
//   frame_err_out   - sticky: line count != HEIGHT at frame end
// Build option: define CAM_TEST_PATTERN_EN to replace camera bytes in pixel_out
// with {line_cnt[4:0], pix_cnt[5:0], pix_cnt[4:0]}.
module camera_capture
  import cam_pkg::*;
#(
  parameter int WIDTH       = CAM_WIDTH,
  parameter int HEIGHT      = CAM_HEIGHT,
  parameter int SYNC_STAGES = CAM_SYNC_STAGES
) (
  input  logic        system_clk_in,
  input  logic        rst_n_in,
  input  logic        cam_pclk_in,
  input  logic        cam_href_in,
  input  logic        cam_vsync_in,
  input  logic [7:0]  cam_data_in,
  output logic [15:0] pixel_out,
  output logic        valid_pixel_out,
  output logic        frame_done_out,
  output logic        line_err_out,
  output logic        frame_err_out
);

  localparam int PW = $clog2(WIDTH + 1);
  localparam int LW = $clog2(HEIGHT + 1);
  localparam logic [PW-1:0] PIX_MAX  = '1;
  localparam logic [LW-1:0] LINE_MAX = '1;
  localparam logic [PW-1:0] WIDTH_C  = PW'(WIDTH);
  localparam logic [LW-1:0] HEIGHT_C = LW'(HEIGHT);

  logic [2:0] ctrl_sync;
  logic [7:0] data_sync;

  sync_ff #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync_ctrl (
    .clk   (system_clk_in),
    .rst_n (rst_n_in),
    .d     ({cam_pclk_in, cam_href_in, cam_vsync_in}),
    .q     (ctrl_sync)
  );

  sync_ff #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_data (
    .clk   (system_clk_in),
    .rst_n (rst_n_in),
    .d     (cam_data_in),
    .q     (data_sync)
  );

  logic       pclk_q, pclk_qq;
  logic       href_q, href_qq;
  logic       vsync_q, vsync_qq;
  logic [7:0] data_q;

  // One aligned register stage for every synced input plus a delayed copy of
  // the control bits for edge detection; data_q lines up with pe
  always_ff @(posedge system_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pclk_q   <= 1'b0;
      pclk_qq  <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      data_q   <= '0;
    end else begin
      pclk_q   <= ctrl_sync[2];
      href_q   <= ctrl_sync[1];
      vsync_q  <= ctrl_sync[0];
      pclk_qq  <= pclk_q;
      href_qq  <= href_q;
      vsync_qq <= vsync_q;
      data_q   <= data_sync;
    end
  end

  logic pe, href_fall, vsync_rise;
  assign pe         = pclk_q & ~pclk_qq;
  assign href_fall  = href_qq & ~href_q;
  assign vsync_rise = vsync_q & ~vsync_qq;

  cam_state_t    state;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic [7:0]    hi_byte;
  rgb565_t       pixel_r;

  // Line close bookkeeping, shared by the plain href-fall path and the case
  // where vsync rises in the same cycle (line is closed before frame end)
  logic          close_line, close_bad;
  logic [PW-1:0] pix_cnt_inc;
  logic [LW-1:0] line_cnt_inc, line_cnt_closed;

  assign close_line      = href_fall && ((state == S_HI) || (state == S_LO));
  assign close_bad       = (pix_cnt != WIDTH_C) || (state == S_LO);
  assign pix_cnt_inc     = (pix_cnt == PIX_MAX) ? pix_cnt : pix_cnt + 1'b1;
  assign line_cnt_inc    = (line_cnt == LINE_MAX) ? line_cnt : line_cnt + 1'b1;
  assign line_cnt_closed = close_line ? line_cnt_inc : line_cnt;

  // Capture FSM with registered outputs; vsync rise takes priority over any
  // pixel activity in the same cycle, so a pending pixel is dropped
  always_ff @(posedge system_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= S_WAIT_VSYNC;
      pix_cnt         <= '0;
      line_cnt        <= '0;
      hi_byte         <= '0;
      pixel_r         <= '0;
      valid_pixel_out <= 1'b0;
      frame_done_out  <= 1'b0;
      line_err_out    <= 1'b0;
      frame_err_out   <= 1'b0;
    end else begin
      valid_pixel_out <= 1'b0;
      frame_done_out  <= 1'b0;
      case (state)
        S_WAIT_VSYNC: begin
          // First vsync after reset only arms capture; the partial frame is discarded
          if (vsync_rise) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            state    <= S_BLANK;
          end
        end
        default: begin
          if (close_line && close_bad) line_err_out <= 1'b1;
          if (vsync_rise) begin
            frame_done_out <= 1'b1;
            if (line_cnt_closed != HEIGHT_C) frame_err_out <= 1'b1;
            if (href_q) line_err_out <= 1'b1;
            pix_cnt  <= '0;
            line_cnt <= '0;
            state    <= S_BLANK;
          end else if (close_line) begin
            line_cnt <= line_cnt_inc;
            pix_cnt  <= '0;
            state    <= S_BLANK;
          end else begin
            case (state)
              S_BLANK: begin
                if (href_q) begin
                  if (pe) begin
                    hi_byte <= data_q;
                    state   <= S_LO;
                  end else begin
                    state <= S_HI;
                  end
                end
              end
              S_HI: begin
                if (pe && href_q) begin
                  hi_byte <= data_q;
                  state   <= S_LO;
                end
              end
              S_LO: begin
                if (pe && href_q) begin
`ifdef CAM_TEST_PATTERN_EN
                  pixel_r <= test_pattern(5'(line_cnt), 6'(pix_cnt));
`else
                  pixel_r <= {hi_byte, data_q};
`endif
                  valid_pixel_out <= 1'b1;
                  pix_cnt         <= pix_cnt_inc;
                  state           <= S_HI;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign pixel_out = pixel_r;

endmodule
